// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared widths, sweep state encoding and clamped next-word helper
package dds_pkg;

  localparam int PHASE_WIDTH_DEFAULT = 10;
  localparam int DWELL_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One extra bit catches wrap past either end of the range; both wrap and overshoot clamp to stop.
  function automatic logic [PHASE_WIDTH_DEFAULT-1:0] next_word(
    input logic [PHASE_WIDTH_DEFAULT-1:0] cur,
    input logic [PHASE_WIDTH_DEFAULT-1:0] step,
    input logic [PHASE_WIDTH_DEFAULT-1:0] stop,
    input logic                           up
  );
    logic [PHASE_WIDTH_DEFAULT:0] sum;
    logic                         past;
    if (up) begin
      sum  = {1'b0, cur} + {1'b0, step};
      past = sum[PHASE_WIDTH_DEFAULT] || (sum[PHASE_WIDTH_DEFAULT-1:0] > stop);
    end else begin
      sum  = {1'b0, cur} - {1'b0, step};
      past = sum[PHASE_WIDTH_DEFAULT] || (sum[PHASE_WIDTH_DEFAULT-1:0] < stop);
    end
    next_word = past ? stop : sum[PHASE_WIDTH_DEFAULT-1:0];
  endfunction

endpackage

// File: rtl/dds_dwell_counter.sv
// rtl/dds_dwell_counter.sv - loadable down-counter with zero flag for per-point dwell
module dds_dwell_counter
  import dds_pkg::*;
#(
  parameter int WIDTH = DWELL_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             decrement,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (decrement && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dds_sweep_controller.sv
// rtl/dds_sweep_controller.sv - steps the DDS tuning word from start to stop, one point per dwell period
module dds_sweep_controller
  import dds_pkg::*;
#(
  parameter int PHASE_WIDTH = PHASE_WIDTH_DEFAULT,
  parameter int DWELL_WIDTH = DWELL_WIDTH_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PHASE_WIDTH-1:0] start_word,
  input  logic [PHASE_WIDTH-1:0] stop_word,
  input  logic [PHASE_WIDTH-1:0] step_word,
  input  logic [DWELL_WIDTH-1:0] dwell_cycles,
  output logic [PHASE_WIDTH-1:0] tuning_word,
  output logic                   acc_clear,
  output logic                   acc_enable,
  output logic                   busy,
  output logic                   done
);

  state_t                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] start_q, stop_q, step_q;
  logic [DWELL_WIDTH-1:0] dwell_q, reload;
  logic                   up_q, up_d;
  logic [PHASE_WIDTH-1:0] tw_d;
  logic                   clr_d, en_d, busy_d, done_d;
  logic                   accept, cnt_load, cnt_zero;

  assign accept = (state_q == IDLE) && start && !abort;
  assign reload = (dwell_q == '0) ? '0 : dwell_q - DWELL_WIDTH'(1);

  dds_dwell_counter #(.WIDTH(DWELL_WIDTH)) u_dwell (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (reload),
    .decrement  (state_q == DWELL),
    .zero       (cnt_zero)
  );

  // Output values are computed for the state being entered so every output is a plain register.
  always_comb begin
    state_d  = state_q;
    tw_d     = tuning_word;
    clr_d    = 1'b0;
    en_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    up_d     = up_q;
    cnt_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LOAD;
          tw_d    = start_word;
          clr_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          tw_d    = '0;
        end else begin
          state_d  = DWELL;
          up_d     = (stop_q >= start_q);
          en_d     = 1'b1;
          busy_d   = 1'b1;
          cnt_load = 1'b1;
        end
      end
      DWELL: begin
        if (abort) begin
          state_d = IDLE;
          tw_d    = '0;
        end else if (cnt_zero && ((tuning_word == stop_q) || (step_q == '0))) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          en_d   = 1'b1;
          busy_d = 1'b1;
          if (cnt_zero) begin
            tw_d     = next_word(tuning_word, step_q, stop_q, up_q);
            cnt_load = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      tuning_word <= '0;
      acc_clear   <= 1'b0;
      acc_enable  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      up_q        <= 1'b0;
      start_q     <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      tuning_word <= tw_d;
      acc_clear   <= clr_d;
      acc_enable  <= en_d;
      busy        <= busy_d;
      done        <= done_d;
      up_q        <= up_d;
      if (accept) begin
        start_q <= start_word;
        stop_q  <= stop_word;
        step_q  <= step_word;
        dwell_q <= dwell_cycles;
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_controller.sv
// tb/tb_dds_sweep_controller.sv - scoreboard bench for dds_sweep_controller
module tb_dds_sweep_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [9:0] start_word = '0;
  logic [9:0] stop_word = '0;
  logic [9:0] step_word = '0;
  logic [15:0] dwell_cycles = '0;
  logic [9:0] tuning_word;
  logic       acc_clear, acc_enable, busy, done;

  dds_sweep_controller dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .start_word   (start_word),
    .stop_word    (stop_word),
    .step_word    (step_word),
    .dwell_cycles (dwell_cycles),
    .tuning_word  (tuning_word),
    .acc_clear    (acc_clear),
    .acc_enable   (acc_enable),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int total = 0;
  int bad = 0;

  typedef struct {
    int cyc;
    int kind;
    int word;
  } exp_t;

  exp_t sb[$];
  int   pts[$];

  task automatic push(input int c, input int k, input int w);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    e.word = w;
    sb.push_back(e);
  endtask

  task automatic check(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // kind 0 = clear (LOAD), 1 = enable (DWELL point), 2 = done
  always @(negedge clock) begin
    int   akind;
    exp_t e;
    if (acc_clear || acc_enable || done) begin
      case ({acc_clear, acc_enable, done})
        3'b100:  akind = 0;
        3'b010:  akind = 1;
        3'b001:  akind = 2;
        default: akind = 3;
      endcase
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL spurious_output: cyc=%0d kind=%0d word=%0d, none expected", cyc, akind, tuning_word);
      end else begin
        e = sb.pop_front();
        if (cyc != e.cyc || akind != e.kind || int'(tuning_word) != e.word ||
            busy != (e.kind != 2)) begin
          bad++;
          $display("FAIL sweep_output: got cyc=%0d kind=%0d word=%0d busy=%0d expected cyc=%0d kind=%0d word=%0d busy=%0d",
                   cyc, akind, tuning_word, busy, e.cyc, e.kind, e.word, (e.kind != 2));
        end
      end
    end
  end

  task automatic launch(input int sw, input int stw, input int stepw, input int dw,
                        input int max_en, input bit with_done, output int e0);
    int d;
    int n_en;
    d = (dw == 0) ? 1 : dw;
    @(negedge clock);
    e0 = cyc + 1;
    push(e0, 0, sw);
    n_en = 0;
    for (int i = 0; i < pts.size(); i++) begin
      for (int j = 0; j < d; j++) begin
        if (n_en < max_en) begin
          push(e0 + 1 + i * d + j, 1, pts[i]);
          n_en++;
        end
      end
    end
    if (with_done) push(e0 + 1 + pts.size() * d, 2, pts[pts.size() - 1]);
    start_word   = 10'(sw);
    stop_word    = 10'(stw);
    step_word    = 10'(stepw);
    dwell_cycles = 16'(dw);
    start        = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check({nm, "_left_unseen"}, sb.size(), 0);
    sb.delete();
    repeat (3) @(negedge clock);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  initial begin
    int e0;

    repeat (2) @(negedge clock);
    check("reset_tuning_word", tuning_word, 0);
    check("reset_acc_clear", acc_clear, 0);
    check("reset_acc_enable", acc_enable, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b0;

    pts = {16, 32, 48, 64};
    launch(16, 64, 16, 4, 99, 1'b1, e0);
    drain("up_sweep");

    pts = {100, 70, 60};
    launch(100, 60, 30, 2, 99, 1'b1, e0);
    drain("down_clamp");

    pts = {40};
    launch(40, 80, 0, 0, 99, 1'b1, e0);
    drain("step_zero");

    pts = {1000, 1016, 1023};
    launch(1000, 1023, 16, 1, 99, 1'b1, e0);
    drain("top_no_wrap");

    pts = {16, 32, 48, 64};
    launch(16, 64, 16, 4, 6, 1'b0, e0);
    wait_cyc(e0 + 6);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_acc_enable", acc_enable, 0);
    check("abort_tuning_word", tuning_word, 0);
    check("abort_done", done, 0);
    drain("abort");

    @(negedge clock);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_clear", acc_clear, 0);
    drain("start_abort");

    pts = {16, 32, 48, 64};
    launch(16, 64, 16, 4, 99, 1'b1, e0);
    wait_cyc(e0 + 3);
    start_word   = 10'd5;
    stop_word    = 10'd6;
    step_word    = 10'd1;
    dwell_cycles = 16'd1;
    start        = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_cyc(e0 + 10);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    drain("start_while_busy");

    pts = {100, 70, 60};
    launch(100, 60, 30, 2, 2, 1'b0, e0);
    wait_cyc(e0 + 2);
    reset = 1'b1;
    #2;
    check("reset_no_edge_busy", busy, 1);
    check("reset_no_edge_enable", acc_enable, 1);
    check("reset_no_edge_word", tuning_word, 100);
    @(negedge clock);
    check("mid_reset_tuning_word", tuning_word, 0);
    check("mid_reset_acc_enable", acc_enable, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_done", done, 0);
    check("mid_reset_acc_clear", acc_clear, 0);
    reset = 1'b0;
    drain("mid_reset");

    pts = {100, 70, 60};
    launch(100, 60, 30, 2, 99, 1'b1, e0);
    drain("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
